axis_crc32_mpeg2_checker: RTL



---
 rtl/axis_crc32_mpeg2_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axis_crc32_mpeg2_checker.sv
// Receive-side CRC32/MPEG-2 frame checker: forwards payload, strips CRC beats, reports residue.
// Optional statistics outputs frm_cnt/err_cnt are enabled by defining AXIS_CRC32_MPEG2_CHK_STATS_EN.
module axis_crc32_mpeg2_checker #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int PKT_WORDS      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      crc_valid,
  output logic                      crc_err,
  output logic [31:0]               crc_calc
`ifdef AXIS_CRC32_MPEG2_CHK_STATS_EN
  ,
  output logic [15:0]               frm_cnt,
  output logic [15:0]               err_cnt
`endif
);

  localparam int          CRC_WORDS = 32 / AXI_DATA_WIDTH;
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [15:0] LAST_DATA = 16'(PKT_WORDS - 1);
  localparam logic [15:0] LAST_CRC  = 16'(CRC_WORDS - 1);

  typedef enum logic {S_DATA, S_CRC} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic [31:0] crc_reg, crc_step;
  logic [15:0] cnt;
  logic        hs, load, cnt_wrap, frame_done;

  // MSB-first serial fold of one beat into the running CRC
  function automatic logic [31:0] crc_fold(input logic [31:0] c,
                                           input logic [AXI_DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < AXI_DATA_WIDTH; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[AXI_DATA_WIDTH-1-i]) ? POLY : '0);
    end
    return r;
  endfunction

  always_comb begin
    crc_step = crc_fold(crc_reg, s_axis_tdata);
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    hs            = 1'b0;
    load          = 1'b0;
    cnt_wrap      = 1'b0;
    frame_done    = 1'b0;
    case (state)
      S_DATA: begin
        s_axis_tready = run && (!m_axis_tvalid || m_axis_tready);
        hs            = s_axis_tready && s_axis_tvalid;
        load          = hs;
        if (hs && cnt == LAST_DATA) begin
          cnt_wrap  = 1'b1;
          state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        s_axis_tready = run;
        hs            = s_axis_tready && s_axis_tvalid;
        if (hs && cnt == LAST_CRC) begin
          cnt_wrap   = 1'b1;
          frame_done = 1'b1;
          state_nxt  = S_DATA;
        end
      end
      default: state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_DATA;
    else          state <= state_nxt;
  end

  // run holds s_axis_tready low while in reset and releases it after the first edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run       <= 1'b0;
      crc_reg   <= '1;
      cnt       <= '0;
      crc_valid <= 1'b0;
      crc_err   <= 1'b0;
      crc_calc  <= '0;
    end else begin
      run       <= 1'b1;
      crc_valid <= 1'b0;
      if (hs) begin
        cnt <= cnt_wrap ? '0 : cnt + 16'd1;
        if (frame_done) begin
          crc_reg   <= '1;
          crc_valid <= 1'b1;
          crc_err   <= (crc_step != '0);
          crc_calc  <= crc_step;
        end else begin
          crc_reg <= crc_step;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_CRC32_MPEG2_CHK_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (crc_valid) begin
      if (frm_cnt != '1) frm_cnt <= frm_cnt + 16'd1;
      if (crc_err && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
